// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS byte stream path.
// Holds the serialiser state encoding and byte-slice indexing.
package prbs_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Bit offset of byte idx in an nbytes word, byte 0 being the MSB byte.
    function automatic int unsigned byte_lsb(
        input int unsigned nbytes,
        input int unsigned idx
    );
        return (nbytes - 1 - idx) * BYTE_W;
    endfunction

endpackage

// File: rtl/prbs_pd_stream_detector.sv
// Sliding byte-window pattern detector with saturating match counter.
// Overlapping matches are reported; clear beats a coincident shift.
module pattern_window_detector
    import prbs_pkg::*;
#(
    parameter int                          WORD_BYTES = 4,
    parameter logic [WORD_BYTES*8-1:0]     PATTERN    = 32'hAABBCCDD,
    parameter int                          MATCH_W    = 16
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               shift_en,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               clear,
    output logic               pattern_detected,
    output logic [MATCH_W-1:0] match_count
);

    localparam int W      = WORD_BYTES * BYTE_W;
    localparam int FILL_W = $clog2(WORD_BYTES + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(WORD_BYTES);

    logic [W-1:0]       win_q, win_d, shifted;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
    logic [MATCH_W-1:0] cnt_q, cnt_d;
    logic               pd_q, pd_d;

    always_comb begin
        win_d    = win_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        pd_d     = 1'b0;
        shifted  = {win_q[W-BYTE_W-1:0], byte_in};
        fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        if (clear) begin
            win_d  = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            win_d  = shifted;
            fill_d = fill_inc;
            if (shifted == PATTERN && fill_inc == FULL) begin
                pd_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            win_q  <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            pd_q   <= 1'b0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            pd_q   <= pd_d;
        end
    end

    assign pattern_detected = pd_q;
    assign match_count      = cnt_q;

endmodule

// File: rtl/prbs_pd_stream.sv
// Word-to-byte serialiser with repeat count, MSB byte first, plus a
// pattern detector watching every accepted output byte.
module prbs_pd_stream
    import prbs_pkg::*;
#(
    parameter int                          WORD_BYTES = 4,
    parameter logic [WORD_BYTES*8-1:0]     PATTERN    = 32'hAABBCCDD,
    parameter int                          CNT_W      = 8,
    parameter int                          MATCH_W    = 16
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_BYTES*8-1:0] in_data,
    input  logic [CNT_W-1:0]        n,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W-1:0]       out_data,
    output logic                    busy,
    input  logic                    clear,
    output logic                    pattern_detected,
    output logic [MATCH_W-1:0]      match_count
);

    localparam int W     = WORD_BYTES * BYTE_W;
    localparam int IDX_W = $clog2(WORD_BYTES);
    localparam int SEL_W = $clog2(W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_BYTES - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     word_q, word_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] lsb;
    logic             hs;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d = in_data;
                    rep_d  = n;
                    idx_d  = '0;
                    if (n != '0) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        idx_d = '0;
                        rep_d = rep_q - 1'b1;
                        if (rep_q == CNT_W'(1)) begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            word_q  <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign hs        = out_valid & out_ready;

    // Byte select comes only from registered word and index.
    assign lsb      = SEL_W'(byte_lsb(WORD_BYTES, 32'(idx_q)));
    assign out_data = word_q[lsb +: BYTE_W];

    pattern_window_detector #(
        .WORD_BYTES (WORD_BYTES),
        .PATTERN    (PATTERN),
        .MATCH_W    (MATCH_W)
    ) u_det (
        .CLK              (CLK),
        .RSTn             (RSTn),
        .shift_en         (hs),
        .byte_in          (out_data),
        .clear            (clear),
        .pattern_detected (pattern_detected),
        .match_count      (match_count)
    );

endmodule

// File: doc/prbs_pd_stream.md
# prbs_pd_stream

Parametrised successor to the byte-serialiser/pattern-detector pair. It accepts a WORD_BYTES-wide word with a repetition count and streams it out MSB byte first, n times, under a valid/ready handshake. In parallel, a sliding-window detector watches the accepted output bytes for PATTERN, pulses on every occurrence (overlaps included) and keeps a saturating match count. It sits between the word source and any byte-wide consumer in the PRBS datapath.

## Interface
- WORD_BYTES, 4: bytes per word and detector window length (≥2).
- PATTERN, 32'hAABBCCDD: WORD_BYTES*8-bit pattern to detect; byte 0 of the window is the MSB byte.
- CNT_W, 8: width of repetition count n.
- MATCH_W, 16: width of match_count.
- CLK  in  1  single clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- in_valid  in  1  load request.
- in_ready  out  1  high exactly when the FSM is in IDLE.
- in_data  in  WORD_BYTES*8  word to stream.
- n  in  CNT_W  repetition count, sampled with in_data.
- out_valid  out  1  output byte available.
- out_ready  in  1  consumer accepts byte.
- out_data  out  8  current byte.
- busy  out  1  high in SEND.
- clear  in  1  synchronous flush of the detector window, fill count and match_count.
- pattern_detected  out  1  one-cycle pulse per match.
- match_count  out  MATCH_W  saturating number of matches since reset/clear.

## Operation
- FSM states are IDLE and SEND. Reset enters IDLE.
- IDLE: in_ready=1, out_valid=0. On in_valid, latch in_data→word and n→rep, and set byte_idx=0.
  - If n==0, the load is consumed and the FSM stays in IDLE.
  - Otherwise the FSM moves to SEND.
- SEND: out_valid=1, out_data=word byte byte_idx (index 0 = bits [WORD_BYTES*8-1 -: 8]).
  - On handshake (out_valid&&out_ready), byte_idx increments.
  - When byte_idx==WORD_BYTES-1, byte_idx wraps to 0 and rep decrements.
  - When rep==1 at that wrap, the FSM moves to IDLE.
  - in_valid is ignored in SEND.
- Without a handshake, word, byte_idx, rep and out_data hold.
- Detector: a WORD_BYTES-byte shift window plus a fill counter saturating at WORD_BYTES.
  - On every handshake, the accepted byte shifts into the LSB byte position and fill increments.
  - The window persists across loads, so matches may span words.
  - Match condition: the post-shift window == PATTERN and post-shift fill == WORD_BYTES.
  - On match, pattern_detected is registered high for one cycle and match_count increments, saturating at 2^MATCH_W-1.
- clear: the window is zeroed, fill=0, match_count=0 and pattern_detected=0 at the next edge.
  - If clear coincides with a handshake, clear wins: the byte is still transmitted but is not entered into the window, and no pulse is produced.
- Reset values: in_ready=1 (IDLE), out_valid=0, out_data=0, busy=0, pattern_detected=0, match_count=0; word, rep, byte_idx, window and fill all 0.
- Reset asserted mid-SEND aborts the word immediately. No partial state survives.

## Timing
- Load accepted at edge k → out_valid and busy high from cycle k+1, showing the first byte.
- With out_ready held high: one byte per cycle, n*WORD_BYTES consecutive valid cycles.
  - in_ready rises in the cycle after the final handshake.
  - The next load can be accepted on that edge, giving one bubble cycle between streams.
- pattern_detected latency: high during the cycle after the handshake edge that completes the match.
- match_count updates on the same edge that raises pattern_detected.
- out_data is driven from registered state only. There is no combinational path from out_ready to out_valid or out_data.

## Structure
- Package prbs_pkg holds:
  - the state typedef (IDLE, SEND);
  - BYTE_W=8;
  - a helper function for byte-slice indexing.
- Sub-module pattern_window_detector (params WORD_BYTES, PATTERN, MATCH_W; ports CLK, RSTn, shift_en, byte_in, clear, pattern_detected, match_count).
- The top level contains the FSM and serialiser and instantiates one pattern_window_detector.

## Test plan
- Single word: load 0xAABBCCDD, n=1, out_ready=1.
  - Bytes AA, BB, CC, DD appear in 4 consecutive cycles.
  - Pulse in the cycle after the DD handshake; match_count=1; in_ready returns high the cycle after the DD handshake.
- Repeat: same word with n=3.
  - 12 bytes and 3 pulses spaced 4 cycles apart; match_count=3; busy high for 12 cycles.
- Backpressure: n=2 with out_ready pseudo-random.
  - out_data is stable through stalls; the exact sequence AA BB CC DD AA BB CC DD is delivered with no loss or duplication; 2 pulses.
- Cross-word and zero-count sequence:
  - Load 0x0000AABB n=1, then 0xCCDD0000 n=1 → exactly one pulse, after the DD handshake.
  - Then n=0 → no out_valid, in_ready stays high, no state change.
- Clear and reset:
  - Assert clear on the DD handshake → no pulse, match_count=0.
  - Assert RSTn low mid-SEND → all outputs at reset values next cycle; the stream restarts cleanly on a new load.
- Saturation: MATCH_W=2, load 0xAABBCCDD with n=5 → match_count sticks at 3; pulses still occur for every match.
